// File: rtl/dff_reg_arbiter_if.sv
// Bundle for the shared-register arbiter: requester side (req/lock/wdata) and
// the arbiter's grant and register outputs.
interface dff_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [IW-1:0]          owner;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;

    modport master (
        output req, lock, wdata,
        input  gnt, owner, busy, q, q_valid
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, owner, busy, q, q_valid
    );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that shares one register among N_REQ writers, with an
// optional lock giving the owner a burst of up to MAX_HOLD writes.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among req starting after ptr
//   OWN   | owner holds gnt; each edge with its req set writes q
module dff_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dff_reg_arbiter_if.slave    bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] PTR_RESET = IW'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;

    // Scan ptr+1, ptr+2, ... so the last owner gets lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        q_d        = q_q;
        q_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = OWN;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    owner_d          = win_idx;
                    hold_cnt_d       = '0;
                end
            end
            OWN: begin
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                end else begin
                    q_d        = bus.wdata[owner_q*WIDTH +: WIDTH];
                    q_valid_d  = 1'b1;
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (!(bus.lock[owner_q] && (hold_cnt_q < HOLD_LAST))) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = owner_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= PTR_RESET;
            hold_cnt_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q == OWN);
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter with N_REQ=4, WIDTH=8, MAX_HOLD=4.
module tb_dff_reg_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dff_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    dff_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.req   = 4'b1111;
        bus.lock  = 4'b0000;
        bus.wdata = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0 ||
                bus.q_valid !== 1'b0 || bus.owner !== 2'd0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got q=%h gnt=%b busy=%b qv=%b owner=%0d exp q=00 gnt=0000 busy=0 qv=0 owner=0",
                         c, bus.q, bus.gnt, bus.busy, bus.q_valid, bus.owner);
            end
        end
        rst     = 1'b0;
        bus.req = '0;
    endtask

    task automatic test_single_write;
        bus.req   = 4'b0001;
        bus.lock  = 4'b0000;
        bus.wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.q_valid !== 1'b0 || bus.owner !== 2'd0) begin
            failures++;
            $display("FAIL single_grant got gnt=%b busy=%b qv=%b owner=%0d exp gnt=0001 busy=1 qv=0 owner=0",
                     bus.gnt, bus.busy, bus.q_valid, bus.owner);
        end
        tick();
        checks++;
        if (bus.q !== 8'hA5 || bus.q_valid !== 1'b1 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_write got q=%h qv=%b gnt=%b busy=%b exp q=a5 qv=1 gnt=0000 busy=0",
                     bus.q, bus.q_valid, bus.gnt, bus.busy);
        end
        bus.req = '0;
        tick();
        checks++;
        if (bus.q !== 8'hA5 || bus.q_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold got q=%h qv=%b busy=%b exp q=a5 qv=0 busy=0",
                     bus.q, bus.q_valid, bus.busy);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_own;
        logic [3:0] exp_gnt;
        logic [7:0] exp_q;
        do_reset();
        bus.req   = 4'b1111;
        bus.lock  = 4'b0000;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int n = 0; n < 5; n++) begin
            exp_own = 2'(n % 4);
            exp_gnt = 4'b0001 << exp_own;
            exp_q   = 8'h10 + 8'(exp_own);
            tick();
            checks++;
            if (bus.gnt !== exp_gnt || bus.owner !== exp_own || bus.q_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_grant n=%0d got gnt=%b owner=%0d qv=%b exp gnt=%b owner=%0d qv=0",
                         n, bus.gnt, bus.owner, bus.q_valid, exp_gnt, exp_own);
            end
            tick();
            checks++;
            if (bus.q !== exp_q || bus.q_valid !== 1'b1 || bus.gnt !== 4'b0000) begin
                failures++;
                $display("FAIL rr_write n=%0d got q=%h qv=%b gnt=%b exp q=%h qv=1 gnt=0000",
                         n, bus.q, bus.q_valid, bus.gnt, exp_q);
            end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_locked_burst;
        do_reset();
        bus.req   = 4'b0011;
        bus.lock  = 4'b0001;
        bus.wdata = {8'h00, 8'h00, 8'h99, 8'h00};
        tick();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL burst_grant got gnt=%b exp gnt=0001", bus.gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            bus.wdata[7:0] = 8'(k);
            tick();
            checks++;
            if (bus.q !== 8'(k) || bus.q_valid !== 1'b1) begin
                failures++;
                $display("FAIL burst_write k=%0d got q=%h qv=%b exp q=%h qv=1", k, bus.q, bus.q_valid, 8'(k));
            end
            checks++;
            if (k < 4 && (bus.gnt !== 4'b0001 || bus.busy !== 1'b1)) begin
                failures++;
                $display("FAIL burst_hold k=%0d got gnt=%b busy=%b exp gnt=0001 busy=1", k, bus.gnt, bus.busy);
            end else if (k == 4 && (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)) begin
                failures++;
                $display("FAIL burst_release got gnt=%b busy=%b exp gnt=0000 busy=0", bus.gnt, bus.busy);
            end
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
            failures++;
            $display("FAIL burst_next got gnt=%b owner=%0d exp gnt=0010 owner=1", bus.gnt, bus.owner);
        end
        tick();
        checks++;
        if (bus.q !== 8'h99 || bus.q_valid !== 1'b1 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL burst_next_write got q=%h qv=%b gnt=%b exp q=99 qv=1 gnt=0000",
                     bus.q, bus.q_valid, bus.gnt);
        end
        bus.req  = '0;
        bus.lock = '0;
        tick();
    endtask

    task automatic test_drop_req;
        do_reset();
        bus.req   = 4'b0001;
        bus.lock  = 4'b0000;
        bus.wdata = {8'h00, 8'h00, 8'h66, 8'h55};
        tick();
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL drop_grant got gnt=%b exp gnt=0001", bus.gnt);
        end
        bus.req = 4'b0010;
        tick();
        checks++;
        if (bus.q !== 8'h00 || bus.q_valid !== 1'b0 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_nowrite got q=%h qv=%b gnt=%b busy=%b exp q=00 qv=0 gnt=0000 busy=0",
                     bus.q, bus.q_valid, bus.gnt, bus.busy);
        end
        bus.req = 4'b0011;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
            failures++;
            $display("FAIL drop_next got gnt=%b owner=%0d exp gnt=0010 owner=1", bus.gnt, bus.owner);
        end
        tick();
        checks++;
        if (bus.q !== 8'h66 || bus.q_valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_next_write got q=%h qv=%b exp q=66 qv=1", bus.q, bus.q_valid);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        bus.req   = 4'b0001;
        bus.lock  = 4'b0001;
        bus.wdata = {8'h00, 8'h00, 8'h00, 8'h77};
        tick();
        tick();
        checks++;
        if (bus.q !== 8'h77 || bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got q=%h gnt=%b busy=%b exp q=77 gnt=0001 busy=1",
                     bus.q, bus.gnt, bus.busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.q_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort got q=%h gnt=%b busy=%b qv=%b exp q=00 gnt=0000 busy=0 qv=0",
                     bus.q, bus.gnt, bus.busy, bus.q_valid);
        end
        rst      = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = 4'b0000;
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
            failures++;
            $display("FAIL midrst_regrant got gnt=%b owner=%0d exp gnt=0001 owner=0", bus.gnt, bus.owner);
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_locked_burst();
        test_drop_req();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
